// File: rtl/systolic_array_os.sv
// Output-stationary systolic GEMM engine: computes one ROWS x COLS tile of
// C = A x B with a run-time reduction depth, then streams the tile out one
// row per ready/valid beat.
module systolic_array_os #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int K_W    = 16,
    parameter int RIDX_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [K_W-1:0]          k_len,
    output logic                    busy,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ROWS*DATA_W-1:0]  a_in_bus,
    input  logic [COLS*DATA_W-1:0]  b_in_bus,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [COLS*ACC_W-1:0]   out_row,
    output logic [RIDX_W-1:0]       out_row_idx,
    output logic                    out_last,
    output logic                    done
);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

    // The last operand needs ROWS+COLS-2 extra cycles to reach the far corner PE.
    localparam int FLUSH_LEN = ROWS + COLS - 1;
    localparam int FCNT_W    = $clog2(FLUSH_LEN + 1);

    state_t              state;
    state_t              state_next;
    logic [K_W-1:0]      k_len_q;
    logic [K_W-1:0]      beat_cnt;
    logic [FCNT_W-1:0]   flush_cnt;
    logic [RIDX_W-1:0]   row_idx;
    logic                done_q;

    logic                accept;
    logic                clear_acc;
    logic                row_hs;
    logic                last_hs;

    // Left-edge (A) and top-edge (B) operands after skewing, with valid tags.
    logic [DATA_W-1:0]   a_inj   [ROWS];
    logic                a_inj_v [ROWS];
    logic [DATA_W-1:0]   b_inj   [COLS];
    logic                b_inj_v [COLS];

    // Operands each PE forwards to its right / lower neighbour.
    logic [DATA_W-1:0]   a_pipe   [ROWS][COLS];
    logic                a_pipe_v [ROWS][COLS];
    logic [DATA_W-1:0]   b_pipe   [ROWS][COLS];
    logic                b_pipe_v [ROWS][COLS];
    logic [ACC_W-1:0]    acc_arr  [ROWS][COLS];

    assign accept    = (state == LOAD) && in_valid;
    assign clear_acc = (state == IDLE) && start;
    assign row_hs    = (state == DRAIN) && out_ready;
    assign last_hs   = row_hs && (row_idx == RIDX_W'(ROWS - 1));

    // Next-state logic for the job sequencer.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (k_len == '0) ? DRAIN : LOAD;
            LOAD:    if (accept && (beat_cnt == k_len_q - K_W'(1))) state_next = FLUSH;
            FLUSH:   if (flush_cnt == FCNT_W'(FLUSH_LEN - 1)) state_next = DRAIN;
            DRAIN:   if (last_hs) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register plus the one-cycle done pulse following the last row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= last_hs;
        end
    end

    // Job length latch and accepted-beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_len_q  <= '0;
            beat_cnt <= '0;
        end else if (clear_acc) begin
            k_len_q  <= k_len;
            beat_cnt <= '0;
        end else if (accept) begin
            beat_cnt <= beat_cnt + K_W'(1);
        end
    end

    // Flush cycle counter, reset whenever the FSM is outside FLUSH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt <= '0;
        end else if (state == FLUSH) begin
            flush_cnt <= flush_cnt + FCNT_W'(1);
        end else begin
            flush_cnt <= '0;
        end
    end

    // Drain row pointer, advanced on each accepted result row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_idx <= '0;
        end else if (clear_acc || last_hs) begin
            row_idx <= '0;
        end else if (row_hs) begin
            row_idx <= row_idx + RIDX_W'(1);
        end
    end

    // Row skew: row i sees its A operand i cycles late; bubbles inject zero/invalid.
    for (genvar i = 0; i < ROWS; i++) begin : g_askew
        logic [DATA_W-1:0] a_src;
        assign a_src = accept ? a_in_bus[(i+1)*DATA_W-1 -: DATA_W] : '0;
        if (i == 0) begin : g_direct
            assign a_inj[i]   = a_src;
            assign a_inj_v[i] = accept;
        end else begin : g_delay
            logic [DATA_W-1:0] dly   [i];
            logic              dly_v [i];
            // Shift chain delaying this row's operand by i cycles.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int d = 0; d < i; d++) begin
                        dly[d]   <= '0;
                        dly_v[d] <= 1'b0;
                    end
                end else begin
                    dly[0]   <= a_src;
                    dly_v[0] <= accept;
                    for (int d = 1; d < i; d++) begin
                        dly[d]   <= dly[d-1];
                        dly_v[d] <= dly_v[d-1];
                    end
                end
            end
            assign a_inj[i]   = dly[i-1];
            assign a_inj_v[i] = dly_v[i-1];
        end
    end

    // Column skew: column j sees its B operand j cycles late.
    for (genvar j = 0; j < COLS; j++) begin : g_bskew
        logic [DATA_W-1:0] b_src;
        assign b_src = accept ? b_in_bus[(j+1)*DATA_W-1 -: DATA_W] : '0;
        if (j == 0) begin : g_direct
            assign b_inj[j]   = b_src;
            assign b_inj_v[j] = accept;
        end else begin : g_delay
            logic [DATA_W-1:0] dly   [j];
            logic              dly_v [j];
            // Shift chain delaying this column's operand by j cycles.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int d = 0; d < j; d++) begin
                        dly[d]   <= '0;
                        dly_v[d] <= 1'b0;
                    end
                end else begin
                    dly[0]   <= b_src;
                    dly_v[0] <= accept;
                    for (int d = 1; d < j; d++) begin
                        dly[d]   <= dly[d-1];
                        dly_v[d] <= dly_v[d-1];
                    end
                end
            end
            assign b_inj[j]   = dly[j-1];
            assign b_inj_v[j] = dly_v[j-1];
        end
    end

    // PE grid: each PE multiplies its incoming pair, accumulates, and forwards.
    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_col
            logic [DATA_W-1:0]          a_here;
            logic                       a_here_v;
            logic [DATA_W-1:0]          b_here;
            logic                       b_here_v;
            logic signed [2*DATA_W-1:0] prod;
            logic [DATA_W-1:0]          a_reg;
            logic                       a_reg_v;
            logic [DATA_W-1:0]          b_reg;
            logic                       b_reg_v;
            logic [ACC_W-1:0]           acc;

            if (j == 0) begin : g_aedge
                assign a_here   = a_inj[i];
                assign a_here_v = a_inj_v[i];
            end else begin : g_ain
                assign a_here   = a_pipe[i][j-1];
                assign a_here_v = a_pipe_v[i][j-1];
            end

            if (i == 0) begin : g_bedge
                assign b_here   = b_inj[j];
                assign b_here_v = b_inj_v[j];
            end else begin : g_bin
                assign b_here   = b_pipe[i-1][j];
                assign b_here_v = b_pipe_v[i-1][j];
            end

            assign prod = $signed(a_here) * $signed(b_here);

            // Forward operands and accumulate only when both tags are valid.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_reg   <= '0;
                    a_reg_v <= 1'b0;
                    b_reg   <= '0;
                    b_reg_v <= 1'b0;
                    acc     <= '0;
                end else begin
                    a_reg   <= a_here;
                    a_reg_v <= a_here_v;
                    b_reg   <= b_here;
                    b_reg_v <= b_here_v;
                    if (clear_acc) begin
                        acc <= '0;
                    end else if (a_here_v && b_here_v) begin
                        acc <= acc + ACC_W'(prod);
                    end
                end
            end

            assign a_pipe[i][j]   = a_reg;
            assign a_pipe_v[i][j] = a_reg_v;
            assign b_pipe[i][j]   = b_reg;
            assign b_pipe_v[i][j] = b_reg_v;
            assign acc_arr[i][j]  = acc;
        end
    end

    // Result row mux; the output bus stays zero outside DRAIN.
    always_comb begin
        out_row = '0;
        if (state == DRAIN) begin
            for (int j = 0; j < COLS; j++) begin
                out_row[j*ACC_W +: ACC_W] = acc_arr[row_idx][j];
            end
        end
    end

    assign busy        = (state != IDLE);
    assign in_ready    = (state == LOAD);
    assign out_valid   = (state == DRAIN);
    assign out_row_idx = (state == DRAIN) ? row_idx : '0;
    assign out_last    = (state == DRAIN) && (row_idx == RIDX_W'(ROWS - 1));
    assign done        = done_q;

endmodule

// File: tb/tb_systolic_array_os.sv
// Directed bench for systolic_array_os: a 2x2 instance for the functional,
// timing, backpressure, abort and start-ignore cases, plus two 4x4 instances
// (32-bit and 16-bit accumulators) for full-range and wrap-around results.
module tb_systolic_array_os;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] k_len = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        start2 = 1'b0;
    logic        start4 = 1'b0;
    logic        start16 = 1'b0;
    logic [15:0] a_bus2 = '0;
    logic [15:0] b_bus2 = '0;
    logic [31:0] a_bus4 = '0;
    logic [31:0] b_bus4 = '0;

    logic        busy2, in_ready2, out_valid2, out_last2, done2;
    logic [63:0] row2;
    logic [0:0]  idx2;

    logic         busy4, in_ready4, out_valid4, out_last4, done4;
    logic [127:0] row4;
    logic [1:0]   idx4;

    logic        busy16, in_ready16, out_valid16, out_last16, done16;
    logic [63:0] row16;
    logic [1:0]  idx16;

    logic         sel16 = 1'b0;
    logic         busy_s, ir_s, ov_s, last_s, done_s;
    logic [127:0] row_s;
    logic [1:0]   idx_s;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    systolic_array_os #(.ROWS(2), .COLS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .k_len(k_len), .busy(busy2),
        .in_valid(in_valid), .in_ready(in_ready2), .a_in_bus(a_bus2), .b_in_bus(b_bus2),
        .out_valid(out_valid2), .out_ready(out_ready), .out_row(row2),
        .out_row_idx(idx2), .out_last(out_last2), .done(done2)
    );

    systolic_array_os dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .k_len(k_len), .busy(busy4),
        .in_valid(in_valid), .in_ready(in_ready4), .a_in_bus(a_bus4), .b_in_bus(b_bus4),
        .out_valid(out_valid4), .out_ready(out_ready), .out_row(row4),
        .out_row_idx(idx4), .out_last(out_last4), .done(done4)
    );

    systolic_array_os #(.ACC_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .k_len(k_len), .busy(busy16),
        .in_valid(in_valid), .in_ready(in_ready16), .a_in_bus(a_bus4), .b_in_bus(b_bus4),
        .out_valid(out_valid16), .out_ready(out_ready), .out_row(row16),
        .out_row_idx(idx16), .out_last(out_last16), .done(done16)
    );

    assign busy_s = sel16 ? busy16 : busy4;
    assign ir_s   = sel16 ? in_ready16 : in_ready4;
    assign ov_s   = sel16 ? out_valid16 : out_valid4;
    assign last_s = sel16 ? out_last16 : out_last4;
    assign done_s = sel16 ? done16 : done4;
    assign row_s  = sel16 ? {64'b0, row16} : row4;
    assign idx_s  = sel16 ? idx16 : idx4;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Two-beat (or shorter) job on the 2x2 instance, up to the first result row.
    task automatic job2(input int k, input logic [15:0] a0, input logic [15:0] b0,
                        input logic [15:0] a1, input logic [15:0] b1,
                        input int bub, input bit poke);
        int t0;
        int guard;
        start2 = 1'b1;
        k_len  = 16'(k);
        t0     = cyc;
        tick();
        start2 = 1'b0;
        check_output("job2_busy", 128'(busy2), 128'(1));
        check_output("job2_in_ready", 128'(in_ready2), (k > 0) ? 128'(1) : 128'(0));
        for (int beat = 0; beat < k; beat++) begin
            if (beat == 1) begin
                for (int n = 0; n < bub; n++) begin
                    in_valid = 1'b0;
                    tick();
                end
            end
            in_valid = 1'b1;
            a_bus2 = (beat == 0) ? a0 : a1;
            b_bus2 = (beat == 0) ? b0 : b1;
            if (poke && beat == 1) begin
                start2 = 1'b1;
                k_len  = '0;
            end
            tick();
            start2 = 1'b0;
        end
        in_valid = 1'b0;
        a_bus2 = '0;
        b_bus2 = '0;
        if (k > 0) check_output("job2_flush_ready", 128'(in_ready2), 128'(0));
        guard = 0;
        while (!out_valid2 && guard < 40) begin
            tick();
            guard++;
        end
        check_output("job2_first_valid_lat", 128'(cyc - t0), (k == 0) ? 128'(1) : 128'(k + bub + 4));
    endtask

    // Drain the 2x2 tile, optionally stalling row 0 and poking start.
    task automatic drain2(input logic [31:0] e00, input logic [31:0] e01,
                          input logic [31:0] e10, input logic [31:0] e11,
                          input int hold, input bit poke);
        logic [63:0] er;
        for (int r = 0; r < 2; r++) begin
            er = (r == 0) ? {e01, e00} : {e11, e10};
            check_output("drain2_valid", 128'(out_valid2), 128'(1));
            check_output("drain2_idx", 128'(idx2), 128'(r));
            check_output("drain2_last", 128'(out_last2), (r == 1) ? 128'(1) : 128'(0));
            check_output("drain2_row", 128'(row2), 128'(er));
            if (r == 0 && hold > 0) begin
                out_ready = 1'b0;
                for (int h = 0; h < hold; h++) begin
                    tick();
                    check_output("hold_valid", 128'(out_valid2), 128'(1));
                    check_output("hold_idx", 128'(idx2), 128'(0));
                    check_output("hold_row", 128'(row2), 128'(er));
                end
                out_ready = 1'b1;
            end
            if (r == 0 && poke) begin
                start2 = 1'b1;
                k_len  = 16'd2;
            end
            tick();
            start2 = 1'b0;
        end
        check_output("drain2_done", 128'(done2), 128'(1));
        check_output("drain2_idle", 128'(busy2), 128'(0));
        check_output("drain2_valid_low", 128'(out_valid2), 128'(0));
        tick();
        check_output("drain2_done_pulse", 128'(done2), 128'(0));
    endtask

    // Uniform-operand job on a 4x4 instance with a full drain.
    task automatic job4(input bit narrow, input int k, input logic [7:0] av,
                        input logic [7:0] bv, input logic [31:0] e);
        int t0;
        int guard;
        logic [127:0] er;
        sel16 = narrow;
        er = narrow ? {64'b0, {4{e[15:0]}}} : {4{e}};
        if (narrow) start16 = 1'b1;
        else        start4  = 1'b1;
        k_len = 16'(k);
        t0 = cyc;
        tick();
        start4  = 1'b0;
        start16 = 1'b0;
        check_output("job4_in_ready", 128'(ir_s), 128'(1));
        in_valid = 1'b1;
        a_bus4 = {4{av}};
        b_bus4 = {4{bv}};
        repeat (k) tick();
        in_valid = 1'b0;
        a_bus4 = '0;
        b_bus4 = '0;
        guard = 0;
        while (!ov_s && guard < 60) begin
            tick();
            guard++;
        end
        check_output("job4_first_valid_lat", 128'(cyc - t0), 128'(k + 8));
        for (int r = 0; r < 4; r++) begin
            check_output("job4_valid", 128'(ov_s), 128'(1));
            check_output("job4_idx", 128'(idx_s), 128'(r));
            check_output("job4_last", 128'(last_s), (r == 3) ? 128'(1) : 128'(0));
            check_output("job4_row", row_s, er);
            tick();
        end
        check_output("job4_done", 128'(done_s), 128'(1));
        tick();
        check_output("job4_idle", 128'(busy_s), 128'(0));
    endtask

    initial begin
        #2 rst_n = 1'b0;
        tick();
        tick();
        check_output("reset_busy", 128'(busy2), 128'(0));
        check_output("reset_in_ready", 128'(in_ready2), 128'(0));
        check_output("reset_out_valid", 128'(out_valid2), 128'(0));
        check_output("reset_done", 128'(done2), 128'(0));
        check_output("reset_row", 128'(row2), 128'(0));
        rst_n = 1'b1;
        tick();

        job2(2, 16'h0301, 16'h0605, 16'h0402, 16'h0807, 0, 1'b0);
        drain2(32'd19, 32'd22, 32'd43, 32'd50, 0, 1'b0);

        job2(2, 16'h0301, 16'h0605, 16'h0402, 16'h0807, 3, 1'b0);
        drain2(32'd19, 32'd22, 32'd43, 32'd50, 0, 1'b0);

        job2(1, 16'h02FF, 16'hFC03, 16'h0000, 16'h0000, 0, 1'b0);
        drain2(32'hFFFF_FFFD, 32'd4, 32'd6, 32'hFFFF_FFF8, 3, 1'b0);

        job2(2, 16'h0301, 16'h0605, 16'h0402, 16'h0807, 0, 1'b1);
        drain2(32'd19, 32'd22, 32'd43, 32'd50, 0, 1'b1);

        job2(0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 1'b0);
        drain2(32'd0, 32'd0, 32'd0, 32'd0, 0, 1'b0);

        start2 = 1'b1;
        k_len  = 16'd4;
        tick();
        start2 = 1'b0;
        in_valid = 1'b1;
        a_bus2 = 16'h0505;
        b_bus2 = 16'h0505;
        tick();
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_output("abort_busy", 128'(busy2), 128'(0));
        check_output("abort_in_ready", 128'(in_ready2), 128'(0));
        check_output("abort_out_valid", 128'(out_valid2), 128'(0));
        check_output("abort_row", 128'(row2), 128'(0));
        check_output("abort_idx", 128'(idx2), 128'(0));
        check_output("abort_last", 128'(out_last2), 128'(0));
        check_output("abort_done", 128'(done2), 128'(0));
        #1 rst_n = 1'b1;
        tick();
        job2(1, 16'h0202, 16'h0303, 16'h0000, 16'h0000, 0, 1'b0);
        drain2(32'd6, 32'd6, 32'd6, 32'd6, 0, 1'b0);

        job4(1'b0, 4, 8'h80, 8'h80, 32'h0001_0000);
        job4(1'b1, 5, 8'h7F, 8'h7F, 32'd15109);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
